// File: rtl/mult_pkg.sv
// Shared constants and types for the shift-add multiplier.
package mult_pkg;

  localparam int W_DEF = 10;
  localparam int CNT_W = $clog2(W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter width for an arbitrary operand width. W=1 is clamped to one bit
  // because a zero-width counter cannot be declared.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mult_datapath.sv
// Multiplier datapath: operand, accumulator and carry registers, W+1-bit
// adder, right shifter and iteration counter.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = cnt_width(W)
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           ld,
  input  logic           step,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  output logic           cnt_last,
  output logic [2*W-1:0] product
);

  logic [W-1:0]  m_q, m_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  q_q, q_d;
  logic          c_q, c_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    sum;

  // One iteration: conditional add into {C,ACC}, then shift {C,ACC,Q} right.
  // product is the post-shift {ACC,Q}, so on the last step it is the result.
  always_comb begin
    sum     = q_q[0] ? ({1'b0, acc_q} + {1'b0, m_q}) : {c_q, acc_q};
    product = {sum, q_q[W-1:1]};

    m_d   = m_q;
    acc_d = acc_q;
    q_d   = q_q;
    c_d   = c_q;
    cnt_d = cnt_q;
    if (ld) begin
      m_d   = a_in;
      q_d   = b_in;
      acc_d = '0;
      c_d   = 1'b0;
      cnt_d = '0;
    end else if (step) begin
      acc_d = product[2*W-1:W];
      q_d   = product[W-1:0];
      c_d   = 1'b0;
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign cnt_last = (cnt_q == CW'(W - 1));

  // Datapath registers; clear has priority over load and step.
  always_ff @(posedge clk) begin
    if (clr) begin
      m_q   <= '0;
      acc_q <= '0;
      q_q   <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      m_q   <= m_d;
      acc_q <= acc_d;
      q_q   <= q_d;
      c_q   <= c_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multiplier.sv
// Sequential radix-2 shift-add unsigned multiplier with start/busy/valid
// handshake. The controller FSM lives here; arithmetic is in mult_datapath.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | iterating, one multiplier bit per cycle (busy)
// DONE  | single cycle with fresh p_out/ovf (valid); start re-accepts
module multiplier
  import mult_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           sclr,
  input  logic           start,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  output logic [2*W-1:0] p_out,
  output logic           ovf,
  output logic           busy,
  output logic           valid
);

  state_e         state_q, state_d;
  logic           ld, step, cnt_last;
  logic [2*W-1:0] product;
  logic [2*W-1:0] p_out_q, p_out_d;
  logic           ovf_q, ovf_d;

  mult_datapath #(.W(W)) u_datapath (
    .clk      (clk),
    .clr      (sclr),
    .ld       (ld),
    .step     (step),
    .a_in     (a_in),
    .b_in     (b_in),
    .cnt_last (cnt_last),
    .product  (product)
  );

  // Next-state, datapath strobes and result capture on the final iteration.
  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    step    = 1'b0;
    p_out_d = p_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ld      = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt_last) begin
          p_out_d = product;
          ovf_d   = |product[2*W-1:W];
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          ld      = 1'b1;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q <= IDLE;
      p_out_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_out_q <= p_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign p_out = p_out_q;
  assign ovf   = ovf_q;
  assign busy  = (state_q == CALC);
  assign valid = (state_q == DONE);

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: directed cases plus random operands
// against a plain-arithmetic product model.
module tb_multiplier;

  localparam int W = 10;

  logic           clk = 1'b0;
  logic           sclr, start;
  logic [W-1:0]   a_in, b_in;
  logic [2*W-1:0] p_out;
  logic           ovf, busy, valid;

  int checks   = 0;
  int failures = 0;

  logic [2*W-1:0] last_p;
  logic           last_ovf;

  always #5 clk = ~clk;

  multiplier #(.W(W)) dut (
    .clk   (clk),
    .sclr  (sclr),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .p_out (p_out),
    .ovf   (ovf),
    .busy  (busy),
    .valid (valid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model_p(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return p[2*W-1:0];
  endfunction

  function automatic logic model_ovf(input int a, input int b);
    return (longint'(a) * longint'(b)) >= (longint'(1) << W);
  endfunction

  // One full operation from IDLE. poke=1 pulses start with junk operands in
  // CALC cycles 3 and 7. Inputs change on negedges, outputs sampled there.
  task automatic run_op(input int a, input int b, input bit poke, input string tag);
    int lat, busy_cnt, both, hold_bad;
    logic [2*W-1:0] exp_p;
    logic           exp_o;
    exp_p = model_p(a, b);
    exp_o = model_ovf(a, b);
    @(negedge clk);
    a_in  = W'(a);
    b_in  = W'(b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    lat = 1; busy_cnt = 0; both = 0; hold_bad = 0;
    while (!valid && lat < 40) begin
      if (busy) busy_cnt++;
      if (busy && valid) both++;
      if (p_out !== last_p || ovf !== last_ovf) hold_bad++;
      @(negedge clk);
      lat++;
      if (poke && (lat == 3 || lat == 7)) begin
        start = 1'b1;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    chk({tag, " latency"}, lat, W + 1);
    chk({tag, " busy_cycles"}, busy_cnt, W);
    chk({tag, " hold_prev"}, hold_bad, 0);
    chk({tag, " busy_valid_overlap"}, both + (busy & valid), 0);
    chk({tag, " p_out"}, p_out, exp_p);
    chk({tag, " ovf"}, ovf, exp_o);
    last_p   = exp_p;
    last_ovf = exp_o;
    @(negedge clk);
    chk({tag, " valid_single"}, valid, 0);
    chk({tag, " idle_after"}, busy, 0);
  endtask

  initial begin
    int lat, hold_bad, vseen, a, b;
    sclr = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    last_p = '0; last_ovf = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst p_out", p_out, 0);
    chk("rst ovf", ovf, 0);
    chk("rst busy", busy, 0);
    chk("rst valid", valid, 0);

    // sclr together with start: request lost
    start = 1'b1; a_in = 10'd5; b_in = 10'd5;
    @(negedge clk);
    chk("sclr_start busy", busy, 0);
    sclr = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("sclr_start still idle", busy, 0);

    run_op(3, 5, 1'b0, "3x5");
    run_op(1023, 1023, 1'b0, "1023x1023");
    run_op(31, 33, 1'b0, "31x33");
    run_op(32, 32, 1'b0, "32x32");
    run_op(0, 777, 1'b0, "0x777");
    run_op(777, 0, 1'b0, "777x0");
    run_op(21, 19, 1'b1, "start_in_calc");

    // sclr in CALC cycle 5 of 100x200
    @(negedge clk);
    a_in = 10'd100; b_in = 10'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort busy_before", busy, 1);
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    chk("abort p_out", p_out, 0);
    chk("abort ovf", ovf, 0);
    chk("abort busy", busy, 0);
    chk("abort valid", valid, 0);
    vseen = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (valid || busy) vseen++;
    end
    chk("abort no_valid", vseen, 0);
    last_p = '0; last_ovf = 1'b0;
    run_op(6, 7, 1'b0, "6x7_after_abort");

    // Back-to-back with start held high
    @(negedge clk);
    a_in = 10'd12; b_in = 10'd12; start = 1'b1;
    @(negedge clk);
    lat = 1;
    while (!valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b first latency", lat, W + 1);
    chk("b2b first p_out", p_out, 144);
    chk("b2b first ovf", ovf, 0);
    a_in = 10'd1000; b_in = 10'd2;
    @(negedge clk);
    start = 1'b0;
    chk("b2b restart busy", busy, 1);
    lat = 1; hold_bad = 0;
    while (!valid && lat < 40) begin
      if (p_out !== 20'd144) hold_bad++;
      @(negedge clk);
      lat++;
    end
    chk("b2b hold 144", hold_bad, 0);
    chk("b2b second latency", lat, W + 1);
    chk("b2b second p_out", p_out, 2000);
    chk("b2b second ovf", ovf, 1);
    last_p = 20'd2000; last_ovf = 1'b1;
    @(negedge clk);
    chk("b2b valid_single", valid, 0);

    // Random operands, mixed ranges
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 2))
        0: begin a = $urandom_range(0, 1023); b = $urandom_range(0, 1023); end
        1: begin a = $urandom_range(0, 40);   b = $urandom_range(0, 40);   end
        default: begin
          a = ($urandom_range(0, 1) == 1) ? 1023 : $urandom_range(0, 1);
          b = $urandom_range(0, 1023);
        end
      endcase
      run_op(a, b, ($urandom_range(0, 3) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiplier.md
# multiplier

Sequential radix-2 shift-add unsigned multiplier, the counterpart of the team's 10-bit restoring divider. Same start/busy/valid handshake and flag style, so both arithmetic units can sit behind one operand/result interface in the CA1 datapath. Accepts two W-bit operands and returns the full 2W-bit product after a fixed W-iteration latency. Raises an overflow flag when the product does not fit in W bits.

## Interface
- W, default 10: operand width; the product is 2W bits wide.
- clk  in  1  single clock; all state changes on the rising edge.
- sclr  in  1  reset, synchronous, active-high; overrides every other input.
- a_in  in  W  multiplicand, unsigned; sampled only on the accepting edge.
- b_in  in  W  multiplier, unsigned; sampled only on the accepting edge.
- start  in  1  request; accepted when state is IDLE or DONE.
- p_out  out  2W  registered product; holds the last completed result.
- ovf  out  1  registered; 1 when p_out[2W-1:W] is nonzero.
- busy  out  1  1 while an operation is iterating.
- valid  out  1  one-cycle pulse marking a fresh p_out/ovf.

## Operation
- State machine: IDLE, CALC, DONE.
- IDLE:
  - start=1 gives the accepting edge, which loads M<=a_in, Q<=b_in, ACC<=0, C<=0, cnt<=0 and moves to CALC.
  - Otherwise stay in IDLE.
- CALC, one iteration per edge:
  - If Q[0]=1: {C,ACC} <= ACC + M (W+1-bit sum). Otherwise {C,ACC} is unchanged.
  - Then shift {C,ACC,Q} right by one, C<=0; cnt<=cnt+1.
  - When cnt=W-1 the iteration is the last one, and that edge also moves to DONE.
  - The last edge writes p_out<={ACC,Q} (post-shift value) and ovf<=|p_out upper half.
- DONE lasts exactly one cycle, with valid=1. Next edge:
  - start=1: accept a new operation and go to CALC (back-to-back, no idle gap).
  - Otherwise go to IDLE.
- start in CALC is ignored; no queueing and no error flag.
- Operand changes after the accepting edge have no effect.
- Arithmetic rules:
  - Unsigned only.
  - The adder carry is kept in C, so 2W-bit results are exact; no truncation.
  - The counter width is ceil(log2(W)).

## Timing
- Reset values: p_out=0, ovf=0, busy=0, valid=0, state=IDLE, cnt=0, M/Q/ACC/C=0.
- Accepting edge at k:
  - busy=1 from edge k through edge k+W (W cycles high).
  - The state is DONE after edge k+W; valid=1 for exactly that one cycle, with busy=0.
- Latency from the accepting edge to a valid result is W+1 cycles.
- Throughput is one result per W+1 cycles with start held high.
- p_out/ovf change only on the last CALC edge. Between operations, and during the next operation, they hold the previous result.
- busy and valid are never 1 in the same cycle. busy is decoded from state==CALC; valid from state==DONE.
- sclr mid-operation: the next edge forces all reset values. The partial product is discarded; no valid pulse.
- sclr and start on the same edge: sclr wins and the request is lost.

## Structure
- Package mult_pkg holds:
  - W default constant;
  - CNT_W = $clog2(W);
  - state enum {IDLE, CALC, DONE}.
- Split mirrors the divider:
  - multiplier is the top, containing the controller FSM.
  - One sub-module, mult_datapath, holds the M/ACC/Q/C registers, the W+1-bit adder, the shifter and the iteration counter. It exposes ld, clr, step, cnt_last and product.

## Test plan
- 3 x 5 from reset:
  - p_out=15, ovf=0.
  - busy high for exactly 10 cycles.
  - valid on cycle 11 after the accepting edge, single cycle.
- Overflow cases:
  - 1023 x 1023 gives p_out=1046529, ovf=1.
  - 31 x 33 gives 1023, ovf=0.
  - 32 x 32 gives 1024, ovf=1.
- Zero operands:
  - 0 x 777 and 777 x 0 give p_out=0, ovf=0, with full 11-cycle latency.
- start pulsed in CALC cycles 3 and 7 with different operands:
  - Ignored; the result is the original product.
  - Exactly one valid pulse.
- sclr asserted in CALC cycle 5 of 100 x 200:
  - Next cycle all outputs are 0 and state is IDLE; no valid.
  - A following 6 x 7 yields 42.
- Back-to-back: start held high with 12 x 12 then 1000 x 2:
  - First result 144; the second operation starts on the DONE edge.
  - Second valid 11 cycles later with p_out=2000, ovf=1.
  - p_out holds 144 throughout the second operation.
